// File: rtl/bullet_pool.sv
// Pool of NUM_BULLETS player bullets: fire-key edge/auto-fire requests, frame-paced
// movement and cooldown, hit clearing, and a zero-latency pixel coverage query.
module bullet_pool #(
  parameter int          NUM_BULLETS = 4,
  parameter logic [7:0]  FIRE_KEY    = 8'h2C,
  parameter int          AUTO_FIRE   = 0,
  parameter int          COOLDOWN    = 8,
  parameter int          SPEED       = 4,
  parameter logic [9:0]  START_Y     = 10'd440,
  parameter logic [9:0]  X_OFFSET    = 10'd15,
  parameter int          BULLET_W    = 2,
  parameter int          BULLET_H    = 8,
  localparam int         SLOT_W      = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_tick,
  input  logic [7:0]             keycode,
  input  logic                   is_playing,
  input  logic [9:0]             player_x,
  input  logic                   hit_valid,
  input  logic [SLOT_W-1:0]      hit_slot,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  output logic                   bullet_on,
  output logic [SLOT_W-1:0]      bullet_slot,
  output logic [NUM_BULLETS-1:0] active_mask,
  output logic [15:0]            shots_fired
);

  localparam logic [9:0]  SPEED_10    = 10'(SPEED);
  localparam logic [7:0]  COOLDOWN_8  = 8'(COOLDOWN);
  localparam logic [10:0] BULLET_W_11 = 11'(BULLET_W);
  localparam logic [10:0] BULLET_H_11 = 11'(BULLET_H);

  logic [NUM_BULLETS-1:0] active_q, active_d;
  logic [9:0]             x_q [NUM_BULLETS];
  logic [9:0]             x_d [NUM_BULLETS];
  logic [9:0]             y_q [NUM_BULLETS];
  logic [9:0]             y_d [NUM_BULLETS];
  logic [7:0]             cooldown_q, cooldown_d;
  logic                   pending_q, pending_d;
  logic                   key_prev_q, key_prev_d;
  logic [15:0]            shots_q, shots_d;

  logic                   key_now;
  logic                   fire_req;
  logic [NUM_BULLETS-1:0] hit_mask;
  logic [NUM_BULLETS-1:0] survive_mask;
  logic [NUM_BULLETS-1:0] free_mask;
  logic                   spawn_found;
  logic [SLOT_W-1:0]      spawn_idx;
  logic                   spawn;

  always_comb begin
    key_now    = (keycode == FIRE_KEY);
    key_prev_d = key_now;
    fire_req   = pending_q | ((AUTO_FIRE != 0) ? key_now : (key_now & ~key_prev_q));

    // A hit only counts against a slot that currently holds a bullet
    hit_mask = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (hit_valid && (hit_slot == SLOT_W'(i))) hit_mask[i] = active_q[i];
    end

    survive_mask = active_q & ~hit_mask;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      if (frame_tick && survive_mask[i]) begin
        if (y_q[i] < SPEED_10) survive_mask[i] = 1'b0;
        else                   y_d[i] = y_q[i] - SPEED_10;
      end
    end

    // The slot being hit this edge is not offered to the spawner
    free_mask   = ~survive_mask & ~hit_mask;
    spawn_found = 1'b0;
    spawn_idx   = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        spawn_found = 1'b1;
        spawn_idx   = SLOT_W'(i);
      end
    end
    spawn = is_playing && frame_tick && fire_req && (cooldown_q == 8'd0) && spawn_found;

    active_d   = survive_mask;
    cooldown_d = cooldown_q;
    pending_d  = fire_req;
    shots_d    = shots_q;

    if (frame_tick) begin
      if (cooldown_q != 8'd0) cooldown_d = cooldown_q - 8'd1;
      pending_d = 1'b0;
    end

    if (spawn) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (spawn_idx == SLOT_W'(i)) begin
          active_d[i] = 1'b1;
          x_d[i]      = player_x + X_OFFSET;
          y_d[i]      = START_Y;
        end
      end
      cooldown_d = COOLDOWN_8;
      if (shots_q != 16'hFFFF) shots_d = shots_q + 16'd1;
    end

    if (!is_playing) begin
      active_d   = '0;
      pending_d  = 1'b0;
      cooldown_d = 8'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      active_q   <= '0;
      cooldown_q <= 8'd0;
      pending_q  <= 1'b0;
      key_prev_q <= 1'b0;
      shots_q    <= 16'd0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i] <= 10'd0;
        y_q[i] <= 10'd0;
      end
    end else begin
      active_q   <= active_d;
      cooldown_q <= cooldown_d;
      pending_q  <= pending_d;
      key_prev_q <= key_prev_d;
      shots_q    <= shots_d;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  // Coverage is evaluated in 11 bits so x+W and y+H cannot wrap
  always_comb begin
    bullet_on   = 1'b0;
    bullet_slot = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (active_q[i]
          && ({1'b0, x_q[i]} <= {1'b0, DrawX})
          && ({1'b0, DrawX} < ({1'b0, x_q[i]} + BULLET_W_11))
          && ({1'b0, y_q[i]} <= {1'b0, DrawY})
          && ({1'b0, DrawY} < ({1'b0, y_q[i]} + BULLET_H_11))) begin
        bullet_on   = 1'b1;
        bullet_slot = SLOT_W'(i);
      end
    end
  end

  assign active_mask = active_q;
  assign shots_fired = shots_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Randomized and directed bench for bullet_pool: three configurations share one
// stimulus stream and are checked every cycle against a per-instance slot model.
module tb_bullet_pool;

  localparam int N  = 4;
  localparam int NI = 3;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] keycode;
  logic       is_playing;
  logic [9:0] player_x;
  logic       hit_valid;
  logic [1:0] hit_slot;
  logic [9:0] DrawX;
  logic [9:0] DrawY;

  logic        bon   [NI];
  logic [1:0]  bslot [NI];
  logic [3:0]  amask [NI];
  logic [15:0] shots [NI];

  int vectors    = 0;
  int miscompares = 0;
  bit check_en   = 1'b0;

  // Instance 0: one-shot, cooldown 8; 1: auto-fire, cooldown 8; 2: one-shot, no cooldown
  int m_auto  [NI] = '{0, 1, 0};
  int m_cdmax [NI] = '{8, 8, 0};

  bit m_act   [NI][N];
  int m_x     [NI][N];
  int m_y     [NI][N];
  int m_cd    [NI];
  int m_shots [NI];
  bit m_pend  [NI];
  bit m_kprev [NI];

  always #5 Clk = ~Clk;

  bullet_pool #(.AUTO_FIRE(0), .COOLDOWN(8)) dut0 (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .is_playing(is_playing), .player_x(player_x), .hit_valid(hit_valid),
    .hit_slot(hit_slot), .DrawX(DrawX), .DrawY(DrawY), .bullet_on(bon[0]),
    .bullet_slot(bslot[0]), .active_mask(amask[0]), .shots_fired(shots[0]));

  bullet_pool #(.AUTO_FIRE(1), .COOLDOWN(8)) dut1 (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .is_playing(is_playing), .player_x(player_x), .hit_valid(hit_valid),
    .hit_slot(hit_slot), .DrawX(DrawX), .DrawY(DrawY), .bullet_on(bon[1]),
    .bullet_slot(bslot[1]), .active_mask(amask[1]), .shots_fired(shots[1]));

  bullet_pool #(.AUTO_FIRE(0), .COOLDOWN(0)) dut2 (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .is_playing(is_playing), .player_x(player_x), .hit_valid(hit_valid),
    .hit_slot(hit_slot), .DrawX(DrawX), .DrawY(DrawY), .bullet_on(bon[2]),
    .bullet_slot(bslot[2]), .active_mask(amask[2]), .shots_fired(shots[2]));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // One clock edge of game rules, applied to the slot list of instance m
  task automatic modelStep(input int m);
    bit key_now, req;
    int hs, pre, idx;
    key_now = (keycode == 8'h2C);
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        m_act[m][i] = 0; m_x[m][i] = 0; m_y[m][i] = 0;
      end
      m_cd[m] = 0; m_pend[m] = 0; m_kprev[m] = 0; m_shots[m] = 0;
      return;
    end
    req = m_pend[m] || ((m_auto[m] != 0) ? key_now : (key_now && !m_kprev[m]));
    m_kprev[m] = key_now;
    if (!is_playing) begin
      for (int i = 0; i < N; i++) m_act[m][i] = 0;
      m_pend[m] = 0;
      m_cd[m] = 0;
      return;
    end
    hs = -1;
    if (hit_valid && m_act[m][hit_slot]) hs = int'(hit_slot);
    if (hs >= 0) m_act[m][hs] = 0;
    if (!frame_tick) begin
      m_pend[m] = req;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m_act[m][i]) begin
        if (m_y[m][i] < 4) m_act[m][i] = 0;
        else m_y[m][i] = m_y[m][i] - 4;
      end
    end
    pre = m_cd[m];
    if (m_cd[m] > 0) m_cd[m] = m_cd[m] - 1;
    if (req && pre == 0) begin
      idx = -1;
      for (int i = 0; i < N; i++) if (idx < 0 && !m_act[m][i] && i != hs) idx = i;
      if (idx >= 0) begin
        m_act[m][idx] = 1;
        m_x[m][idx] = (int'(player_x) + 15) % 1024;
        m_y[m][idx] = 440;
        m_cd[m] = m_cdmax[m];
        if (m_shots[m] < 65535) m_shots[m] = m_shots[m] + 1;
      end
    end
    m_pend[m] = 0;
  endtask

  always @(posedge Clk) begin
    for (int m = 0; m < NI; m++) modelStep(m);
  end

  // Every cycle: compare all outputs of all instances with the model
  always @(negedge Clk) begin
    int exp_mask, exp_on, exp_slot;
    if (check_en) begin
      for (int m = 0; m < NI; m++) begin
        exp_mask = 0;
        exp_on   = 0;
        exp_slot = 0;
        for (int i = N - 1; i >= 0; i--) begin
          if (m_act[m][i]) begin
            exp_mask = exp_mask | (1 << i);
            if (m_x[m][i] <= int'(DrawX) && int'(DrawX) < m_x[m][i] + 2 &&
                m_y[m][i] <= int'(DrawY) && int'(DrawY) < m_y[m][i] + 8) begin
              exp_on   = 1;
              exp_slot = i;
            end
          end
        end
        checkOutput($sformatf("active_mask[%0d]", m), 32'(amask[m]), 32'(exp_mask));
        checkOutput($sformatf("shots_fired[%0d]", m), 32'(shots[m]), 32'(m_shots[m]));
        checkOutput($sformatf("bullet_on[%0d]", m), 32'(bon[m]), 32'(exp_on));
        checkOutput($sformatf("bullet_slot[%0d]", m), 32'(bslot[m]), 32'(exp_slot));
      end
    end
  end

  task automatic doTick();
    frame_tick = 1'b1;
    applyStimulus(1);
    frame_tick = 1'b0;
    applyStimulus(1);
  endtask

  task automatic pressKey();
    keycode = 8'h2C;
    applyStimulus(1);
    keycode = 8'h00;
    applyStimulus(1);
  endtask

  task automatic pulseReset();
    Reset = 1'b1;
    applyStimulus(1);
    Reset = 1'b0;
  endtask

  task automatic probe(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; keycode = 8'h00; is_playing = 1'b0;
    player_x = 10'd0; hit_valid = 1'b0; hit_slot = 2'd0; DrawX = 10'd0; DrawY = 10'd0;
    applyStimulus(1);
    check_en = 1'b1;
    applyStimulus(1);
    checkOutput("lit_reset_mask", 32'(amask[0]), 32'd0);
    checkOutput("lit_reset_shots", 32'(shots[0]), 32'd0);
    checkOutput("lit_reset_on", 32'(bon[0]), 32'd0);

    // First shot: slot 0 at (115,440), then moves to 436
    Reset = 1'b0; is_playing = 1'b1; player_x = 10'd100; keycode = 8'h2C;
    applyStimulus(3);
    keycode = 8'h00;
    doTick();
    checkOutput("lit_first_mask", 32'(amask[0]), 32'd1);
    checkOutput("lit_first_shots", 32'(shots[0]), 32'd1);
    probe(115, 440); checkOutput("lit_spawn_on", 32'(bon[0]), 32'd1);
    probe(116, 447); checkOutput("lit_spawn_corner", 32'(bon[0]), 32'd1);
    probe(117, 440); checkOutput("lit_spawn_right_edge", 32'(bon[0]), 32'd0);
    probe(115, 448); checkOutput("lit_spawn_bottom_edge", 32'(bon[0]), 32'd0);
    doTick();
    probe(115, 436); checkOutput("lit_moved_on", 32'(bon[0]), 32'd1);
    probe(115, 435); checkOutput("lit_moved_above", 32'(bon[0]), 32'd0);

    // Key held for 20 frames: one-shot spawns once, auto-fire on ticks 1, 10, 19
    pulseReset();
    keycode = 8'h2C;
    repeat (20) doTick();
    keycode = 8'h00;
    applyStimulus(1);
    checkOutput("lit_hold_oneshot", 32'(shots[0]), 32'd1);
    checkOutput("lit_hold_auto_shots", 32'(shots[1]), 32'd3);
    checkOutput("lit_hold_auto_mask", 32'(amask[1]), 32'h7);

    // Fill all four slots, then a press with the pool full is dropped
    pulseReset();
    for (int k = 0; k < 4; k++) begin
      pressKey();
      repeat (9) doTick();
    end
    pressKey();
    doTick();
    checkOutput("lit_full_mask", 32'(amask[0]), 32'hF);
    checkOutput("lit_full_shots", 32'(shots[0]), 32'd4);
    hit_valid = 1'b1; hit_slot = 2'd3;
    applyStimulus(1);
    hit_valid = 1'b0;
    doTick();
    checkOutput("lit_dropped_mask", 32'(amask[0]), 32'h7);
    checkOutput("lit_dropped_shots", 32'(shots[0]), 32'd4);

    // Hit on slot 1 coincides with a spawn: slot 1 is skipped, slot 3 is used
    pressKey();
    frame_tick = 1'b1; hit_valid = 1'b1; hit_slot = 2'd1;
    applyStimulus(1);
    frame_tick = 1'b0; hit_valid = 1'b0;
    applyStimulus(1);
    checkOutput("lit_hit_spawn_mask", 32'(amask[0]), 32'hD);
    checkOutput("lit_hit_spawn_shots", 32'(shots[0]), 32'd5);
    hit_valid = 1'b1; hit_slot = 2'd1;
    applyStimulus(1);
    hit_valid = 1'b0;
    applyStimulus(1);
    checkOutput("lit_hit_inactive", 32'(amask[0]), 32'hD);

    // Bullet reaches the top (y=0) and its slot is reused by a same-tick spawn
    pulseReset();
    pressKey();
    doTick();
    repeat (110) doTick();
    checkOutput("lit_top_still_active", 32'(amask[0]), 32'd1);
    probe(115, 0); checkOutput("lit_top_on", 32'(bon[0]), 32'd1);
    pressKey();
    doTick();
    checkOutput("lit_reuse_mask", 32'(amask[0]), 32'd1);
    checkOutput("lit_reuse_shots", 32'(shots[0]), 32'd2);
    probe(115, 440); checkOutput("lit_reuse_on", 32'(bon[0]), 32'd1);

    // Overlapping bullets on the no-cooldown instance: slot 0 at y=400, slot 1 at y=404
    pulseReset();
    pressKey(); doTick();
    pressKey(); doTick();
    repeat (9) doTick();
    probe(116, 405);
    checkOutput("lit_overlap_on", 32'(bon[2]), 32'd1);
    checkOutput("lit_overlap_slot", 32'(bslot[2]), 32'd0);
    probe(117, 405); checkOutput("lit_overlap_right", 32'(bon[2]), 32'd0);
    probe(115, 409);
    checkOutput("lit_lower_only_on", 32'(bon[2]), 32'd1);
    checkOutput("lit_lower_only_slot", 32'(bslot[2]), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      Reset      = ($urandom_range(0, 199) == 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0)
        keycode = ($urandom_range(0, 1) == 0) ? 8'h2C : 8'($urandom_range(0, 255));
      is_playing = ($urandom_range(0, 49) != 0);
      hit_valid  = ($urandom_range(0, 7) == 0);
      hit_slot   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)
        player_x = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(1000, 1023))
                                               : 10'($urandom_range(90, 130));
      DrawX = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                          : 10'(int'(player_x) + 15 + $urandom_range(0, 3) - 1);
      DrawY = 10'($urandom_range(0, 479));
      applyStimulus(1);
    end

    Reset = 1'b0; frame_tick = 1'b0; hit_valid = 1'b0;
    applyStimulus(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
